// File: rtl/insn_stream_encoder.sv
// rtl/insn_stream_encoder.sv - packs field-level instruction beats into 32-bit words and writes them to imem
// Optional IMM_CHECK_EN: reject I-type immediates that do not fit a signed 17-bit value.
module insn_stream_encoder #(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [4:0]        in_aluop,
  input  logic [26:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err_illegal,
  output logic              overflow
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_next_addr;
  logic [31:0]       r_data;
  logic [ADDR_W:0]   r_count;
  logic              r_done;
  logic              r_err;
  logic              r_ovf;

  logic [31:0]       w_word;
  logic              w_legal;
  logic              w_accept;
  logic              w_at_top;

  always_comb begin
    w_word  = '0;
    w_legal = 1'b0;
    case (in_op)
      5'b00000: begin
        w_word  = {in_op, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
        w_legal = 1'b1;
      end
      5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110: begin
        w_word  = {in_op, in_rd, in_rs, in_imm[16:0]};
`ifdef IMM_CHECK_EN
        w_legal = (in_imm[26:16] == '0) || (&in_imm[26:16]);
`else
        w_legal = 1'b1;
`endif
      end
      5'b00001, 5'b00011, 5'b10110, 5'b10101: begin
        w_word  = {in_op, in_imm};
        w_legal = 1'b1;
      end
      5'b00100: begin
        w_word  = {in_op, in_rd, 22'b0};
        w_legal = 1'b1;
      end
      default: begin
        w_word  = '0;
        w_legal = 1'b0;
      end
    endcase
  end

  assign w_accept = in_valid & r_in_ready;
  // The final address ends the session; the pointer never wraps back.
  assign w_at_top = (r_next_addr == {ADDR_W{1'b1}});

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= BASE_ADDR;
      r_next_addr <= BASE_ADDR;
      r_data      <= '0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_LOAD;
            r_in_ready  <= 1'b1;
            r_done      <= 1'b0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
            r_next_addr <= BASE_ADDR;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (w_legal) begin
              r_we    <= 1'b1;
              r_addr  <= r_next_addr;
              r_data  <= w_word;
              r_count <= r_count + 1'b1;
              if (w_at_top) begin
                r_ovf <= 1'b1;
              end else begin
                r_next_addr <= r_next_addr + 1'b1;
              end
            end else begin
              r_err <= 1'b1;
            end
            if (in_last || (w_legal && w_at_top)) begin
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign imem_we     = r_we;
  assign imem_addr   = r_addr;
  assign imem_data   = r_data;
  assign count       = r_count;
  assign done        = r_done;
  assign err_illegal = r_err;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_insn_stream_encoder.sv
// tb/tb_insn_stream_encoder.sv - self-checking bench for insn_stream_encoder with a behavioural model
`timescale 1ns/1ps
module tb_insn_stream_encoder;

  localparam int AW  = 3;
  localparam int TOP = (1 << AW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_op = '0, in_rd = '0, in_rs = '0, in_rt = '0, in_shamt = '0, in_aluop = '0;
  logic [26:0]   in_imm = '0;
  logic          in_last = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic [AW:0]   count;
  logic          done, err_illegal, overflow;

  insn_stream_encoder #(.ADDR_W(AW), .BASE_ADDR(3'd0)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt),
    .in_aluop(in_aluop), .in_imm(in_imm), .in_last(in_last), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_data(imem_data), .count(count), .done(done),
    .err_illegal(err_illegal), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference encoding written from the opcode classes, not from the DUT structure.
  function automatic void ref_encode(input logic [4:0] op, rd, rs, rt, sh, al, input logic [26:0] imm,
                                     output logic [31:0] w, output bit legal);
    w = 32'h0;
    legal = 1'b1;
    if (op == 5'd0)
      w = (32'(op) << 27) | (32'(rd) << 22) | (32'(rs) << 17) | (32'(rt) << 12) | (32'(sh) << 7) | (32'(al) << 2);
    else if (op inside {5'd5, 5'd7, 5'd8, 5'd2, 5'd6}) begin
      w = (32'(op) << 27) | (32'(rd) << 22) | (32'(rs) << 17) | (32'(imm) & 32'h1FFFF);
`ifdef IMM_CHECK_EN
      legal = ((imm >> 16) == 27'd0) || ((imm >> 16) == 27'h7FF);
`endif
    end else if (op inside {5'd1, 5'd3, 5'd22, 5'd21})
      w = (32'(op) << 27) | 32'(imm);
    else if (op == 5'd4)
      w = (32'(op) << 27) | (32'(rd) << 22);
    else
      legal = 1'b0;
  endfunction

  bit          m_valid = 1'b0;
  bit          m_loading, m_we, m_done, m_err, m_ovf;
  int          m_addr, m_next, m_cnt;
  logic [31:0] m_data;

  int          log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    logic [31:0] w;
    bit legal, fin;
    if (imem_we === 1'b1) begin
      log_addr.push_back(int'(imem_addr));
      log_data.push_back(imem_data);
      log_cyc.push_back(cyc);
    end
    if (m_valid) begin
      chk("in_ready", 64'(in_ready), 64'(m_loading));
      chk("imem_we", 64'(imem_we), 64'(m_we));
      chk("imem_addr", 64'(imem_addr), 64'(m_addr));
      chk("imem_data", 64'(imem_data), 64'(m_data));
      chk("count", 64'(count), 64'(m_cnt));
      chk("done", 64'(done), 64'(m_done));
      chk("err_illegal", 64'(err_illegal), 64'(m_err));
      chk("overflow", 64'(overflow), 64'(m_ovf));
    end
    if (reset) begin
      m_valid = 1'b1; m_loading = 0; m_we = 0; m_done = 0; m_err = 0; m_ovf = 0;
      m_addr = 0; m_next = 0; m_cnt = 0; m_data = 32'h0;
    end else if (m_valid) begin
      m_we = 1'b0;
      if (!m_loading) begin
        if (start) begin
          m_loading = 1; m_done = 0; m_cnt = 0; m_err = 0; m_ovf = 0; m_next = 0;
        end
      end else if (in_valid) begin
        ref_encode(in_op, in_rd, in_rs, in_rt, in_shamt, in_aluop, in_imm, w, legal);
        fin = in_last;
        if (legal) begin
          m_we = 1; m_addr = m_next; m_data = w; m_cnt++;
          if (m_next == TOP) begin m_ovf = 1; fin = 1; end
          else m_next++;
        end else m_err = 1;
        if (fin) begin m_loading = 0; m_done = 1; end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [4:0] op, rd, rs, rt, sh, al, input logic [26:0] imm,
                      input logic last, input int max_wait, output bit acc);
    in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_shamt = sh; in_aluop = al;
    in_imm = imm; in_last = last; in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < max_wait && !acc; i++) begin
      acc = in_ready;
      @(posedge clock); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_ok(input string nm, input logic [4:0] op, rd, rs, rt, sh, al,
                         input logic [26:0] imm, input logic last);
    bit acc;
    send(op, rd, rs, rt, sh, al, imm, last, 20, acc);
    chk({nm, "_accepted"}, 64'(acc), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    bit acc;
    idle(2);
    reset = 1'b0;
    #0;
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_data", 64'(imem_data), 64'd0);

    // 1: single addi with in_last
    b = log_addr.size();
    pulse_start();
    send_ok("t1", 5'd5, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 27'd5, 1'b1);
    chk("t1_we_next", 64'(imem_we), 64'd1);
    idle(2);
    chk("t1_nwrites", 64'(log_addr.size() - b), 64'd1);
    chk("t1_addr", 64'(log_addr[b]), 64'd0);
    chk("t1_data", 64'(log_data[b]), 64'h28400005);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_count", 64'(count), 64'd1);

    // 2: R-type then j, back-to-back
    b = log_addr.size();
    pulse_start();
    send_ok("t2r", 5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd1, 27'd0, 1'b0);
    send_ok("t2j", 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 27'd100, 1'b1);
    idle(2);
    chk("t2_nwrites", 64'(log_addr.size() - b), 64'd2);
    chk("t2_data0", 64'(log_data[b]), 64'h00C22004);
    chk("t2_addr0", 64'(log_addr[b]), 64'd0);
    chk("t2_data1", 64'(log_data[b+1]), 64'h08000064);
    chk("t2_addr1", 64'(log_addr[b+1]), 64'd1);
    chk("t2_consec", 64'(log_cyc[b+1] - log_cyc[b]), 64'd1);

    // 3: jr, illegal opcode, then addi lands at the next address only
    b = log_addr.size();
    pulse_start();
    send_ok("t3jr", 5'd4, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 27'd0, 1'b0);
    send_ok("t3bad", 5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 27'd1, 1'b0);
    send_ok("t3addi", 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 27'd1, 1'b1);
    idle(2);
    chk("t3_nwrites", 64'(log_addr.size() - b), 64'd2);
    chk("t3_jr", 64'(log_data[b]), 64'h27C00000);
    chk("t3_addr1", 64'(log_addr[b+1]), 64'd1);
    chk("t3_data1", 64'(log_data[b+1]), 64'h28000001);
    chk("t3_err", 64'(err_illegal), 64'd1);
    chk("t3_count", 64'(count), 64'd2);

    // 5: out-of-range I-type immediate
    b = log_addr.size();
    pulse_start();
    send_ok("t5", 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 27'h0020000, 1'b1);
    idle(2);
    chk("t5_done", 64'(done), 64'd1);
`ifdef IMM_CHECK_EN
    chk("t5_nwrites", 64'(log_addr.size() - b), 64'd0);
    chk("t5_err", 64'(err_illegal), 64'd1);
`else
    chk("t5_nwrites", 64'(log_addr.size() - b), 64'd1);
    chk("t5_data", 64'(log_data[b]), 64'h28000000);
    chk("t5_err", 64'(err_illegal), 64'd0);
`endif

    // 4: fill the whole address space without in_last
    b = log_addr.size();
    pulse_start();
    for (int i = 0; i <= TOP; i++)
      send_ok("t4", 5'd7, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 27'(i), 1'b0);
    send(5'd7, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 27'd99, 1'b0, 5, acc);
    chk("t4_extra_refused", 64'(acc), 64'd0);
    chk("t4_nwrites", 64'(log_addr.size() - b), 64'(TOP + 1));
    chk("t4_last_addr", 64'(log_addr[log_addr.size()-1]), 64'(TOP));
    chk("t4_overflow", 64'(overflow), 64'd1);
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_ready", 64'(in_ready), 64'd0);
    chk("t4_count", 64'(count), 64'(TOP + 1));

    // 6: reset in the middle of a session
    b = log_addr.size();
    pulse_start();
    send_ok("t6a", 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 27'd7, 1'b0);
    send_ok("t6b", 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 27'd8, 1'b0);
    reset = 1'b1;
    in_valid = 1'b1; in_op = 5'd1; in_imm = 27'd9;
    @(posedge clock); #1;
    chk("t6_we", 64'(imem_we), 64'd0);
    chk("t6_ready", 64'(in_ready), 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_addr", 64'(imem_addr), 64'd0);
    chk("t6_data", 64'(imem_data), 64'd0);
    chk("t6_flags", 64'({done, err_illegal, overflow}), 64'd0);
    reset = 1'b0;
    idle(3);
    in_valid = 1'b0;
    idle(1);
    chk("t6_nwrites", 64'(log_addr.size() - b), 64'd2);
    chk("t6_idle_ready", 64'(in_ready), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
